// File: rtl/cheri_tsmap_ctrl.sv
// cheri_tsmap_ctrl: owner of the revocation shadow bitmap (1 bit per 8-byte heap
// granule, 32 granules per map word) with a 1-cycle read port for the revocation
// checker and a range paint engine that sets/clears bits for [base, top) by
// read-modify-write, using only cycles the read port leaves free.
//
// Optional feature: define CHERI_TSMAP_CLR_ALL_EN to add clr_all_i and a CLR
// state that zeroes the whole map.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   tsmap_cs_i/addr_i        checker read request (word index, [10:0] used)
//   tsmap_rdata_o            map word, valid the cycle after tsmap_cs_i, held otherwise
//   paint_valid_i/ready_o    paint request handshake (ready = engine idle)
//   paint_base_i/top_i       byte range [base, top)
//   paint_set_i              1 = set (revoke), 0 = clear
//   paint_done_o/err_o       completion pulse, err qualifies an invalid range
//   clr_all_i                (CHERI_TSMAP_CLR_ALL_EN) zero the entire map
module cheri_tsmap_ctrl #(
  parameter logic [31:0] HeapBase  = 32'h8000_0000,
  parameter int unsigned TSMapSize = 127
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tsmap_cs_i,
  input  logic [15:0] tsmap_addr_i,
  output logic [31:0] tsmap_rdata_o,
  input  logic        paint_valid_i,
  output logic        paint_ready_o,
  input  logic [31:0] paint_base_i,
  input  logic [31:0] paint_top_i,
  input  logic        paint_set_i,
  output logic        paint_done_o,
`ifdef CHERI_TSMAP_CLR_ALL_EN
  input  logic        clr_all_i,
`endif
  output logic        paint_err_o
);

  localparam int unsigned MapDepth = TSMapSize + 1;
  localparam int unsigned WordAw   = $clog2(MapDepth);
  localparam int unsigned MapBits  = MapDepth * 32;

  typedef enum logic [2:0] {
    StIdle,
    StChk,
    StRd,
    StMw,
    StDone
`ifdef CHERI_TSMAP_CLR_ALL_EN
    , StClr
`endif
  } state_e;

  logic [31:0]       mem [MapDepth];
  state_e            state_q;
  logic [WordAw-1:0] w_q, first_q, last_q;
  logic [4:0]        lo_q, hi_q;
  logic              set_q;
  logic [31:0]       rd_q;

  logic [31:0]       base_off;
  logic [32:0]       top_off;
  logic [29:0]       gt, gt_m1;
  logic              req_err, req_empty;
  logic [WordAw-1:0] rd_idx;
  logic [31:0]       rd_word;
  logic              addr_oor;
  logic [4:0]        lo_eff, hi_eff;
  logic [31:0]       mask;
  logic              mem_we;
  logic [31:0]       wr_data;
  logic              unused_bits;

  // Request decode: granule bounds of [base, top) with top rounded up.
  assign base_off  = paint_base_i - HeapBase;
  assign top_off   = {1'b0, paint_top_i} + 33'd7 - {1'b0, HeapBase};
  assign gt        = top_off[32:3];
  assign gt_m1     = gt - 30'd1;
  assign req_err   = (paint_base_i < HeapBase) || (paint_top_i < paint_base_i) ||
                     (gt > 30'(MapBits));
  assign req_empty = (paint_top_i == paint_base_i);

  // Single read port: the checker owns the address whenever it requests.
  assign rd_idx   = tsmap_cs_i ? tsmap_addr_i[WordAw-1:0] : w_q;
  assign rd_word  = mem[rd_idx];
  assign addr_oor = tsmap_addr_i[10:0] > 11'(TSMapSize);

  // Bit mask for the current word: bounds only apply on the first/last word.
  assign lo_eff = (w_q == first_q) ? lo_q : 5'd0;
  assign hi_eff = (w_q == last_q) ? hi_q : 5'd31;
  assign mask   = ({32{1'b1}} << lo_eff) & ({32{1'b1}} >> (5'd31 - hi_eff));

  assign unused_bits = ^{tsmap_addr_i[15:11], base_off[31:WordAw+8], base_off[2:0],
                         top_off[2:0], gt_m1[29:WordAw+5]};

  // Write decode: writes only happen in cycles the checker leaves free.
  always_comb begin
    mem_we  = 1'b0;
    wr_data = (rd_q & ~mask) | (set_q ? mask : 32'd0);
    if (!tsmap_cs_i) begin
      if (state_q == StMw) mem_we = 1'b1;
`ifdef CHERI_TSMAP_CLR_ALL_EN
      if (state_q == StClr) begin
        mem_we  = 1'b1;
        wr_data = 32'd0;
      end
`endif
    end
  end

  // Map storage (not reset).
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[w_q] <= wr_data;
  end

  // Read port register and paint engine FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      tsmap_rdata_o <= 32'd0;
      paint_ready_o <= 1'b1;
      paint_done_o  <= 1'b0;
      paint_err_o   <= 1'b0;
      w_q           <= '0;
      first_q       <= '0;
      last_q        <= '0;
      lo_q          <= 5'd0;
      hi_q          <= 5'd0;
      set_q         <= 1'b0;
      rd_q          <= 32'd0;
    end else begin
      if (tsmap_cs_i) tsmap_rdata_o <= addr_oor ? 32'd0 : rd_word;

      case (state_q)
        StIdle: begin
`ifdef CHERI_TSMAP_CLR_ALL_EN
          if (clr_all_i) begin
            state_q       <= StClr;
            paint_ready_o <= 1'b0;
            w_q           <= '0;
          end else
`endif
          if (paint_valid_i && paint_ready_o) begin
            paint_ready_o <= 1'b0;
            set_q         <= paint_set_i;
            first_q       <= base_off[WordAw+7:8];
            lo_q          <= base_off[7:3];
            last_q        <= gt_m1[WordAw+4:5];
            hi_q          <= gt_m1[4:0];
            // Invalid or empty ranges complete immediately without touching the map.
            if (req_err || req_empty) begin
              state_q      <= StDone;
              paint_done_o <= 1'b1;
              paint_err_o  <= req_err;
            end else begin
              state_q <= StChk;
            end
          end
        end
        StChk: begin
          w_q     <= first_q;
          state_q <= StRd;
        end
        StRd: begin
          if (!tsmap_cs_i) begin
            rd_q    <= rd_word;
            state_q <= StMw;
          end
        end
        StMw: begin
          if (!tsmap_cs_i) begin
            if (w_q == last_q) begin
              state_q      <= StDone;
              paint_done_o <= 1'b1;
            end else begin
              w_q     <= w_q + WordAw'(1);
              state_q <= StRd;
            end
          end
        end
        StDone: begin
          paint_done_o  <= 1'b0;
          paint_err_o   <= 1'b0;
          paint_ready_o <= 1'b1;
          state_q       <= StIdle;
        end
`ifdef CHERI_TSMAP_CLR_ALL_EN
        StClr: begin
          if (!tsmap_cs_i) begin
            if (w_q == WordAw'(TSMapSize)) begin
              state_q      <= StDone;
              paint_done_o <= 1'b1;
            end else begin
              w_q <= w_q + WordAw'(1);
            end
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cheri_tsmap_ctrl.sv
// Testbench for cheri_tsmap_ctrl: scoreboard of expected read data and paint
// completions, checked against a bit-granular map model.
module tb_cheri_tsmap_ctrl;

  localparam logic [31:0] HB = 32'h8000_0000;
  localparam int MapWords = 128;

  typedef struct {
    logic err;
    int   lat;
  } paint_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tsmap_cs = 1'b0;
  logic [15:0] tsmap_addr = 16'd0;
  logic [31:0] tsmap_rdata;
  logic        paint_valid = 1'b0;
  logic        paint_ready;
  logic [31:0] paint_base = 32'd0;
  logic [31:0] paint_top = 32'd0;
  logic        paint_set = 1'b0;
  logic        paint_done;
  logic        paint_err;
`ifdef CHERI_TSMAP_CLR_ALL_EN
  logic        clr_all = 1'b0;
`endif

  cheri_tsmap_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tsmap_cs_i   (tsmap_cs),
    .tsmap_addr_i (tsmap_addr),
    .tsmap_rdata_o(tsmap_rdata),
    .paint_valid_i(paint_valid),
    .paint_ready_o(paint_ready),
    .paint_base_i (paint_base),
    .paint_top_i  (paint_top),
    .paint_set_i  (paint_set),
    .paint_done_o (paint_done),
`ifdef CHERI_TSMAP_CLR_ALL_EN
    .clr_all_i    (clr_all),
`endif
    .paint_err_o  (paint_err)
  );

  always #5 clk = ~clk;

  logic [31:0] rq[$];
  paint_exp_t  pq[$];
  logic [31:0] model [MapWords];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  logic        cs_seen = 1'b0;
  logic [31:0] last_exp = 32'd0;
  paint_exp_t  mon_pe;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    cs_seen <= tsmap_cs;
  end

  // Output monitor: pops the scoreboards when the DUT produces data or a done pulse.
  always @(negedge clk) begin
    if (cs_seen) begin
      if (rq.size() == 0) check_eq("rd_unexpected", 32'd1, 32'd0);
      else check_eq("rdata", tsmap_rdata, rq.pop_front());
    end
    if (paint_done) begin
      if (pq.size() == 0) begin
        check_eq("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_pe = pq.pop_front();
        check_eq("done_lat", 32'(cyc - accept_cyc), 32'(mon_pe.lat));
        check_eq("done_err", 32'(paint_err), 32'(mon_pe.err));
      end
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic paint_exp_t calc_exp(input logic [31:0] base, input logic [31:0] top,
                                          input int stalls);
    paint_exp_t  e;
    logic [63:0] gb, gt;
    gb    = ({32'd0, base} - {32'd0, HB}) >> 3;
    gt    = ({32'd0, top} + 64'd7 - {32'd0, HB}) >> 3;
    e.err = 1'b0;
    e.lat = 1;
    if (base < HB || top < base || gt > 64'd4096) e.err = 1'b1;
    else if (top != base) e.lat = 2 + 2 * int'((gt - 64'd1) / 32 - gb / 32 + 64'd1) + stalls;
    return e;
  endfunction

  task automatic apply_model(input logic [31:0] base, input logic [31:0] top, input logic set);
    paint_exp_t e;
    int gb, gt;
    e = calc_exp(base, top, 0);
    if (e.err || top == base) return;
    gb = int'((base - HB) >> 3);
    gt = int'((top - HB + 32'd7) >> 3);
    for (int g = gb; g < gt; g++) model[g / 32][g % 32] = set;
  endtask

  task automatic start_paint(input logic [31:0] base, input logic [31:0] top, input logic set,
                             input int stalls, input bit track);
    paint_base  = base;
    paint_top   = top;
    paint_set   = set;
    paint_valid = 1'b1;
    accept_cyc  = cyc;
    if (track) begin
      pq.push_back(calc_exp(base, top, stalls));
      exp_done++;
    end
    step();
    paint_valid = 1'b0;
    @(negedge clk);
    check_eq("ready_busy", 32'(paint_ready), 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt < exp_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", 32'(done_cnt), 32'(exp_done));
    @(negedge clk);
    check_eq("ready_idle", 32'(paint_ready), 32'd1);
  endtask

  task automatic paint(input logic [31:0] base, input logic [31:0] top, input logic set);
    start_paint(base, top, set, 0, 1'b1);
    wait_done();
    apply_model(base, top, set);
  endtask

  task automatic rd(input int w);
    tsmap_cs   = 1'b1;
    tsmap_addr = 16'(w);
    if (w < MapWords) last_exp = model[w];
    else last_exp = 32'd0;
    rq.push_back(last_exp);
    step();
    tsmap_cs = 1'b0;
  endtask

  task automatic rd_exp(input int w, input logic [31:0] exp);
    tsmap_cs   = 1'b1;
    tsmap_addr = 16'(w);
    last_exp   = exp;
    rq.push_back(exp);
    step();
    tsmap_cs = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < MapWords; w++) model[w] = 32'd0;

    @(negedge clk);
    check_eq("rst_rdata", tsmap_rdata, 32'd0);
    check_eq("rst_ready", 32'(paint_ready), 32'd1);
    check_eq("rst_done", 32'(paint_done), 32'd0);
    check_eq("rst_err", 32'(paint_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Bring the unreset map to a known all-zero state.
    paint(HB, HB + 32'h8000, 1'b0);
    rd(0); rd(64); rd(127);

    paint(HB + 32'h10, HB + 32'h28, 1'b1);
    rd_exp(0, 32'h0000_001C);

    paint(HB + 32'hF8, HB + 32'h110, 1'b1);
    rd_exp(0, 32'h8000_001C);
    rd_exp(1, 32'h0000_0003);

    paint(HB, HB + 32'h100, 1'b1);
    paint(HB + 32'h40, HB + 32'h48, 1'b0);
    rd_exp(0, 32'hFFFF_FEFF);
    repeat (3) step();
    check_eq("rdata_hold", tsmap_rdata, last_exp);

    // Ten checker cycles while the engine sits in its read phase.
    start_paint(HB + 32'h200, HB + 32'h208, 1'b1, 10, 1'b1);
    step();
    rd(2); rd(0); rd(1); rd(200); rd(127); rd(2); rd(2047); rd(3); rd(1); rd(2);
    wait_done();
    apply_model(HB + 32'h200, HB + 32'h208, 1'b1);
    rd_exp(2, 32'h0000_0001);

    paint(HB - 32'd8, HB + 32'd8, 1'b1);
    paint(HB, HB + 32'h8001, 1'b1);
    paint(HB + 32'h100, HB + 32'hF8, 1'b1);
    rd(0); rd(1); rd(127);

    paint(HB + 32'h7FF8, HB + 32'h8000, 1'b1);
    rd_exp(127, 32'h8000_0000);
    paint(HB + 32'h300, HB + 32'h300, 1'b1);
    rd(3);

    // A second request while busy must be ignored.
    start_paint(HB + 32'hA00, HB + 32'h1500, 1'b1, 0, 1'b1);
    paint_base  = HB - 32'd8;
    paint_top   = HB + 32'd8;
    paint_valid = 1'b1;
    repeat (3) step();
    paint_valid = 1'b0;
    wait_done();
    apply_model(HB + 32'hA00, HB + 32'h1500, 1'b1);
    for (int w = 9; w <= 21; w++) rd(w);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] b, t;
      int fw, lw;
      b = HB + 32'($urandom_range(32'h3000, 32'h7000));
      t = b + 32'($urandom_range(1, 32'h900));
      paint(b, t, 1'($urandom_range(0, 1)));
      fw = int'((b - HB) >> 8) - 1;
      lw = int'((t - HB + 32'd7) >> 8) + 1;
      for (int w = fw; w <= lw && w < MapWords; w++) rd(w);
    end

    // Reset in the middle of a paint over words 30..40.
    start_paint(HB + 32'h1E00, HB + 32'h2900, 1'b1, 0, 1'b0);
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ready", 32'(paint_ready), 32'd1);
    check_eq("midrst_done", 32'(paint_done), 32'd0);
    check_eq("midrst_rdata", tsmap_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 30; w <= 32; w++) model[w] = 32'hFFFF_FFFF;
    step();
    for (int w = 29; w <= 41; w++) rd(w);
    repeat (4) step();
    check_eq("midrst_no_done", 32'(done_cnt), 32'(exp_done));

`ifdef CHERI_TSMAP_CLR_ALL_EN
    begin
      paint_exp_t ce;
      paint_base  = HB;
      paint_top   = HB + 32'd8;
      paint_set   = 1'b1;
      paint_valid = 1'b1;
      clr_all     = 1'b1;
      accept_cyc  = cyc;
      ce.err      = 1'b0;
      ce.lat      = 134;
      pq.push_back(ce);
      exp_done++;
      step();
      paint_valid = 1'b0;
      clr_all     = 1'b0;
      check_eq("clr_ready", 32'(paint_ready), 32'd0);
      for (int w = 0; w < 5; w++) rd(w);
      wait_done();
      for (int w = 0; w < MapWords; w++) model[w] = 32'd0;
      for (int w = 0; w < MapWords; w++) rd(w);
    end
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
